// File: rtl/lif_population.sv
// Time-multiplexed population of leaky integrate-and-fire neurons.
// One neuron is updated per accepted input; membrane and refractory state live in per-neuron arrays.
module lif_population #(
  parameter int                 N          = 128,
  parameter logic signed [31:0] V_TH       = 32'sd30720,
  parameter logic signed [31:0] V_RESET    = 32'sd0,
  parameter int                 LEAK_SHIFT = 4,
  parameter int                 REFRAC     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_in,
  input  logic        i_valid,
  input  logic        resync,
  output logic        spike_out,
  output logic        spike_valid,
  output logic [6:0]  spike_index,
  output logic [31:0] v_out,
  output logic        sweep_done,
  output logic [7:0]  spike_count
);

  localparam logic [6:0] LAST = 7'(N - 1);

  logic signed [31:0] v_mem [N];
  logic [3:0]         rc_mem [N];

  logic [6:0]         idx_q, idx_d, slot;
  logic               in_vld_q;
  logic signed [31:0] in_data_q;
  logic [6:0]         in_slot_q;
  logic               first_pass_q;
  logic [7:0]         tally_q, tally_inc;

  logic               spike_out_q, spike_valid_q, sweep_done_q;
  logic [6:0]         spike_index_q;
  logic [31:0]        v_out_q;
  logic [7:0]         spike_count_q;

  logic signed [31:0] v_rd, v_sat, v_wr;
  logic [3:0]         rc_rd, rc_wr;
  logic signed [33:0] sum;
  logic               spike;

  // resync redirects the incoming input to slot 0 in the same cycle
  always_comb begin
    slot  = resync ? '0 : idx_q;
    idx_d = slot;
    if (i_valid) idx_d = (slot == LAST) ? '0 : slot + 7'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      in_vld_q  <= 1'b0;
      in_data_q <= '0;
      in_slot_q <= '0;
    end else begin
      idx_q     <= idx_d;
      in_vld_q  <= i_valid;
      in_data_q <= i_in;
      in_slot_q <= slot;
    end
  end

  // Stale array contents are masked until the first full sweep has written every slot
  always_comb begin
    v_rd  = first_pass_q ? V_RESET : v_mem[in_slot_q];
    rc_rd = first_pass_q ? '0 : rc_mem[in_slot_q];
    sum   = 34'(v_rd) - 34'(v_rd >>> LEAK_SHIFT) + 34'(in_data_q);
    if (sum > 34'sd2147483647)       v_sat = 32'sh7FFFFFFF;
    else if (sum < -34'sd2147483648) v_sat = 32'sh80000000;
    else                             v_sat = sum[31:0];
    spike = (rc_rd == '0) && (v_sat >= V_TH);
    v_wr  = v_sat;
    rc_wr = rc_rd;
    if (rc_rd != '0) begin
      v_wr  = V_RESET;
      rc_wr = rc_rd - 4'd1;
    end else if (spike) begin
      v_wr  = V_RESET;
      rc_wr = 4'(REFRAC);
    end
    tally_inc = (tally_q == 8'hFF) ? 8'hFF : tally_q + 8'(spike);
  end

  always_ff @(posedge clk) begin
    if (in_vld_q) begin
      v_mem[in_slot_q]  <= v_wr;
      rc_mem[in_slot_q] <= rc_wr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_pass_q  <= 1'b1;
      tally_q       <= '0;
      spike_out_q   <= 1'b0;
      spike_valid_q <= 1'b0;
      spike_index_q <= '0;
      v_out_q       <= '0;
      sweep_done_q  <= 1'b0;
      spike_count_q <= '0;
    end else begin
      spike_valid_q <= in_vld_q;
      sweep_done_q  <= in_vld_q && (in_slot_q == LAST);
      if (in_vld_q) begin
        spike_out_q   <= spike;
        v_out_q       <= v_wr;
        spike_index_q <= in_slot_q;
      end
      // A completing sweep latches its tally even if resync arrives in the same cycle
      if (in_vld_q && (in_slot_q == LAST)) begin
        spike_count_q <= tally_inc;
        tally_q       <= '0;
        first_pass_q  <= 1'b0;
      end else if (resync) begin
        tally_q <= '0;
      end else if (in_vld_q) begin
        tally_q <= tally_inc;
      end
    end
  end

  assign spike_out   = spike_out_q;
  assign spike_valid = spike_valid_q;
  assign spike_index = spike_index_q;
  assign v_out       = v_out_q;
  assign sweep_done  = sweep_done_q;
  assign spike_count = spike_count_q;

endmodule

// File: tb/tb_lif_population.sv
// Scoreboard bench for lif_population: a behavioural neuron model predicts each output transaction.
module tb_lif_population;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_in = '0;
  logic        i_valid = 1'b0;
  logic        resync = 1'b0;
  logic        spike_out, spike_valid, sweep_done;
  logic [6:0]  spike_index;
  logic [31:0] v_out;
  logic [7:0]  spike_count;

  lif_population #(.N(128), .V_TH(32'sd30720), .V_RESET(32'sd0), .LEAK_SHIFT(4), .REFRAC(2)) dut (
    .clk(clk), .reset(reset), .i_in(i_in), .i_valid(i_valid), .resync(resync),
    .spike_out(spike_out), .spike_valid(spike_valid), .spike_index(spike_index),
    .v_out(v_out), .sweep_done(sweep_done), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sp;
    logic [31:0] v;
    logic [6:0]  idx;
    logic        sd;
    logic [7:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n0_q[$];
  int   cnt_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;

  longint m_v [128];
  int     m_rc [128];
  bit     m_fp;
  int     m_idx, m_tally, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, want, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (sweep_done) check("sd_qualified", 32'(spike_valid), 32'd1);
    if (spike_valid) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("latency", cyc, e.cyc);
        check("spike_out", 32'(spike_out), 32'(e.sp));
        check("v_out", v_out, e.v);
        check("spike_index", 32'(spike_index), 32'(e.idx));
        check("sweep_done", 32'(sweep_done), 32'(e.sd));
        check("spike_count", 32'(spike_count), 32'(e.cnt));
        if (spike_index == 7'd0) n0_q.push_back(int'(v_out));
        if (sweep_done) cnt_q.push_back(int'(spike_count));
      end
    end
  end

  task automatic model_reset();
    m_idx = 0; m_fp = 1'b1; m_tally = 0; m_cnt = 0;
  endtask

  task automatic step(input logic vld, input logic [31:0] d, input logic rs);
    longint vr, s;
    int     rr;
    exp_t   x;
    @(negedge clk);
    i_valid = vld; i_in = d; resync = rs;
    if (rs) begin m_idx = 0; m_tally = 0; end
    if (vld) begin
      vr = m_fp ? 0 : m_v[m_idx];
      rr = m_fp ? 0 : m_rc[m_idx];
      x.sp = 1'b0;
      if (rr != 0) begin
        m_v[m_idx] = 0; m_rc[m_idx] = rr - 1;
      end else begin
        s = vr - (vr >>> 4) + longint'($signed(d));
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        if (s >= 30720) begin
          x.sp = 1'b1; m_v[m_idx] = 0; m_rc[m_idx] = 2;
        end else begin
          m_v[m_idx] = s;
        end
      end
      x.v   = 32'(m_v[m_idx]);
      x.idx = 7'(m_idx);
      x.sd  = (m_idx == 127);
      if (m_tally < 255) m_tally += int'(x.sp);
      if (x.sd) begin
        m_cnt = m_tally; m_tally = 0; m_fp = 1'b0;
      end
      x.cnt = 8'(m_cnt);
      x.cyc = cyc + 2;
      sb.push_back(x);
      m_idx = (m_idx + 1) % 128;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; i_valid = 1'b0; resync = 1'b0;
    sb.delete();
    model_reset();
    @(negedge clk);
    check("rst_spike_valid", 32'(spike_valid), 32'd0);
    check("rst_spike_out", 32'(spike_out), 32'd0);
    check("rst_v_out", v_out, 32'd0);
    check("rst_sweep_done", 32'(sweep_done), 32'd0);
    check("rst_spike_index", 32'(spike_index), 32'd0);
    check("rst_spike_count", 32'(spike_count), 32'd0);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  int n0_exp [13] = '{4096, 7936, 11536, 14911, 18076, 21043, 23824, 26431, 28876, 0, 0, 0, 4096};

  initial begin
    model_reset();
    do_reset();

    // Constant current integration, spike, refractory, recovery
    n0_q.delete(); cnt_q.delete();
    for (int i = 0; i < 13 * 128; i++) step(1'b1, 32'd4096, 1'b0);
    idle(3);
    check("n0_sweeps", 32'(n0_q.size()), 32'd13);
    for (int i = 0; i < 13; i++)
      if (i < n0_q.size()) check($sformatf("n0_v_sweep%0d", i + 1), 32'(n0_q[i]), 32'(n0_exp[i]));
    check("cnt_sweeps", 32'(cnt_q.size()), 32'd13);
    if (cnt_q.size() >= 11) begin
      check("cnt_sweep9", 32'(cnt_q[8]), 32'd0);
      check("cnt_sweep10", 32'(cnt_q[9]), 32'd128);
      check("cnt_sweep11", 32'(cnt_q[10]), 32'd0);
    end

    // Reset mid-sweep 3 with stale arrays, then restart
    do_reset();
    for (int i = 0; i < 2 * 128 + 64; i++) step(1'b1, 32'd4096, 1'b0);
    do_reset();
    n0_q.delete();
    for (int i = 0; i < 128; i++) step(1'b1, 32'd4096, 1'b0);
    idle(3);
    check("restart_n0_count", 32'(n0_q.size()), 32'd1);
    if (n0_q.size() != 0) check("restart_n0_v", 32'(n0_q[0]), 32'd4096);

    // Saturation at both extremes
    do_reset();
    for (int i = 0; i < 128; i++) step(1'b1, 32'h7FFFFFFF, 1'b0);
    for (int i = 0; i < 4 * 128; i++) step(1'b1, 32'h80000000, 1'b0);

    // Gapped valid
    do_reset();
    for (int i = 0; i < 3 * 130; i++) step(i % 3 == 0, 32'($urandom_range(0, 12000)), 1'b0);

    // Resync mid-sweep with and without valid
    do_reset();
    for (int i = 0; i < 128; i++) step(1'b1, 32'h7FFFFFFF, 1'b0);
    for (int i = 0; i < 57; i++) step(1'b1, 32'd0, 1'b0);
    step(1'b1, 32'd5000, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 32'd5000, 1'b0);
    step(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 32'($urandom_range(0, 40000)), 1'b0);
    idle(3);
    check("resync_cnt_hold", 32'(spike_count), 32'd128);

    // Random mix of gaps and occasional resync
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 32'($urandom_range(0, 20000)), $urandom_range(0, 99) == 0);

    idle(4);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++; n_err++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $fatal(1);
  end

endmodule

// File: doc/lif_population.md
LIF_POPULATION -- requirements
Module: lif_population

Interface
REQ-001 Parameter N, default 128, neuron count; index width 7 bits.
REQ-002 Parameter V_TH, default 32'sd30720, firing threshold (scale 1024 = 1.0).
REQ-003 Parameter V_RESET, default 32'sd0, post-spike and refractory membrane value.
REQ-004 Parameter LEAK_SHIFT, default 4, leak term = v >>> LEAK_SHIFT.
REQ-005 Parameter REFRAC, default 2, refractory length in sweeps (0..15).
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-high.
REQ-008 i_in  input  32  signed synaptic current for current neuron slot (scale 1024).
REQ-009 i_valid  input  1  qualifies i_in; one neuron processed per asserted cycle.
REQ-010 resync  input  1  synchronous; forces slot index to 0, stored state untouched.
REQ-011 spike_out  output  1  registered spike flag for processed neuron.
REQ-012 spike_valid  output  1  one-cycle strobe qualifying spike_out, spike_index, v_out.
REQ-013 spike_index  output  7  index of processed neuron.
REQ-014 v_out  output  32  signed membrane value written back for that neuron.
REQ-015 sweep_done  output  1  one-cycle pulse when neuron N-1 processed.
REQ-016 spike_count  output  8  spikes in last completed sweep; latched at sweep_done.

Function
REQ-017 Block SHALL keep per-neuron arrays v[N] (32-bit signed) and rc[N] (4-bit refractory count), read-modify-write by slot index.
REQ-018 Slot index SHALL increment by 1 per accepted i_valid, wrap N-1 -> 0; hold otherwise.
REQ-019 On i_valid with rc==0: v_next = v - (v >>> LEAK_SHIFT) + i_in, computed 34-bit signed, saturated to [32'h80000000, 32'h7FFFFFFF].
REQ-020 If saturated v_next >= V_TH (signed): spike_out=1, store v=V_RESET, rc=REFRAC.
REQ-021 Otherwise: spike_out=0, store v=v_next, rc unchanged (0).
REQ-022 On i_valid with rc!=0: i_in ignored, spike_out=0, store v=V_RESET, rc=rc-1.
REQ-023 Latency: outputs for input accepted at edge k SHALL be valid after edge k+1 (spike_valid high exactly one cycle per accepted input).
REQ-024 i_valid SHALL be accepted every cycle back-to-back with no stall; no hazard since consecutive slots differ (N>=2).
REQ-025 v_out SHALL equal the value stored back (V_RESET on spike or refractory).
REQ-026 Sweep counter SHALL count spike_out=1 within a sweep (saturate at 255), copy to spike_count and clear at sweep_done.
REQ-027 sweep_done SHALL assert in the same cycle as spike_valid for index N-1.
REQ-028 resync with i_valid in same cycle: index forced to 0 first, input processed as neuron 0, next index 1.
REQ-029 resync mid-sweep SHALL clear the in-sweep spike tally without pulsing sweep_done; spike_count holds.
REQ-030 first_pass flag: during first sweep after reset, read v and rc SHALL be treated as V_RESET and 0 (arrays not cleared by reset).
REQ-031 first_pass SHALL clear when neuron N-1 is processed.

Reset
REQ-032 On reset: index=0, first_pass=1, spike_out=0, spike_valid=0, spike_index=0, v_out=0, sweep_done=0, spike_count=0, in-sweep tally=0.
REQ-033 Reset asserted mid-sweep SHALL abort immediately; no spike_valid generated for the in-flight input.
REQ-034 Array contents SHALL NOT require reset; REQ-030 guarantees defined behaviour.

Verification
REQ-035 Reset, then i_in=4096 every cycle to all 128 neurons: neuron 0 v_out sweeps 1..9 = 4096, 7936, 11536, 14911, 18076, 21043, 23824, 26431, 28876; sweep 10 spike_out=1, v_out=0, spike_count=128.
REQ-036 Continue REQ-035: sweeps 11,12 spike_out=0, v_out=0 (refractory); sweep 13 v_out=4096.
REQ-037 i_in=32'h7FFFFFFF for one sweep after reset: every neuron spikes, v_out=0; i_in=32'h80000000 repeated: v_out clamps at 32'h80000000, never wraps positive, no spikes.
REQ-038 i_valid gapped (1 of 3 cycles): spike_valid follows each accepted input by exactly one cycle; spike_index increments 0..127 then 0; sweep_done once per 128 inputs.
REQ-039 resync with i_valid at index 57: spike_index=0 for that input, next 1; no sweep_done; spike_count unchanged.
REQ-040 reset asserted at index 64 in sweep 3, then REQ-035 stimulus: sequence restarts at 4096 for every neuron (first_pass masking stale RAM).
